// File: rtl/fft_power_framer_if.sv
// Stream bundle for fft_power_framer: FFT bin input side plus power/bin output side.
// With FFT_POWER_DROPCNT_EN defined it also carries the dropped-frame counter.
interface fft_power_framer_if #(
  parameter int IW       = 18,
  parameter int OW       = 32,
  parameter int FFT_SIZE = 256
);
  localparam int BW = $clog2(FFT_SIZE);

  logic            i_ce;
  logic [2*IW-1:0] i_result;
  logic            i_sync;
  logic            i_ready;
  logic            o_valid;
  logic [OW-1:0]   o_power;
  logic [BW-1:0]   o_bin;
  logic            o_last;
  logic            o_overrun;
`ifdef FFT_POWER_DROPCNT_EN
  logic [15:0]     o_drop_count;
`endif

  modport master (
    output i_ce, i_result, i_sync, i_ready,
    input  o_valid, o_power, o_bin, o_last, o_overrun
`ifdef FFT_POWER_DROPCNT_EN
    , input o_drop_count
`endif
  );

  modport slave (
    input  i_ce, i_result, i_sync, i_ready,
    output o_valid, o_power, o_bin, o_last, o_overrun
`ifdef FFT_POWER_DROPCNT_EN
    , output o_drop_count
`endif
  );
endinterface

// File: rtl/fft_power_framer.sv
// Per-bin power of the half FFT spectrum, framed through a two-bank ping-pong store.
// Optional: define FFT_POWER_DROPCNT_EN to add the saturating o_drop_count output.
module fft_power_framer #(
  parameter int IW       = 18,
  parameter int OW       = 32,
  parameter int FFT_SIZE = 256
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  fft_power_framer_if.slave bus
);
  localparam int            BW       = $clog2(FFT_SIZE);
  localparam int            NB       = FFT_SIZE / 2 + 1;
  localparam int            SHIFT    = 2 * IW - OW;
  localparam logic [BW-1:0] LAST_BIN = BW'(FFT_SIZE / 2);

  typedef enum logic [1:0] {WAIT_SYNC, CAPTURE, SKIP} cap_state_e;

  cap_state_e    state, state_n;
  logic [BW-1:0] bin_cnt, bin_cnt_n;
  logic          wr_bank, wr_bank_n;
  logic          dropping, dropping_n;
  logic [1:0]    full;

  logic          w_en, w_last, w_drop;
  logic [BW-1:0] w_addr;

  // ---------------- capture FSM ----------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= WAIT_SYNC;
      bin_cnt  <= '0;
      wr_bank  <= 1'b0;
      dropping <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      state    <= state_n;
      bin_cnt  <= bin_cnt_n;
      wr_bank  <= wr_bank_n;
      dropping <= dropping_n;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, otherwise untaken branches infer latches.
    state_n    = state;
    bin_cnt_n  = bin_cnt;
    wr_bank_n  = wr_bank;
    dropping_n = dropping;
    w_en       = 1'b0;
    w_last     = 1'b0;
    w_drop     = dropping;
    w_addr     = bin_cnt;
    if (bus.i_ce) begin
      if (bus.i_sync) begin
        // A sync always restarts at bin 0; an occupied target bank diverts the frame.
        state_n    = CAPTURE;
        bin_cnt_n  = BW'(1);
        dropping_n = full[wr_bank];
        w_drop     = full[wr_bank];
        w_en       = 1'b1;
        w_addr     = '0;
      end else begin
        case (state)
          CAPTURE: begin
            w_en = 1'b1;
            if (bin_cnt == LAST_BIN) begin
              w_last    = 1'b1;
              bin_cnt_n = '0;
              state_n   = SKIP;
              if (!dropping) wr_bank_n = ~wr_bank;
            end else begin
              bin_cnt_n = bin_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- squarer pipeline ----------------
  logic signed [IW-1:0]   in_re, in_im;
  logic signed [2*IW-1:0] re_ext, im_ext;
  logic [2*IW-1:0]        re_sq, im_sq;
  logic [BW-1:0]          s1_addr;
  logic                   s1_bank, s1_wr, s1_full, s1_drop;
  logic [OW-1:0]          wr_data;

  assign in_re  = bus.i_result[2*IW-1:IW];
  assign in_im  = bus.i_result[IW-1:0];
  assign re_ext = in_re;
  assign im_ext = in_im;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_wr   <= 1'b0;
      s1_full <= 1'b0;
      s1_drop <= 1'b0;
    end else begin
      s1_wr   <= w_en & ~w_drop;
      s1_full <= w_last & ~w_drop;
      s1_drop <= w_last & w_drop;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_en) begin
      re_sq   <= $unsigned(re_ext * re_ext);
      im_sq   <= $unsigned(im_ext * im_ext);
      s1_addr <= w_addr;
      s1_bank <= wr_bank;
    end
  end

  // The sum cannot overflow 2*IW bits; the top OW bits are kept, untrounded.
  assign wr_data = OW'((re_sq + im_sq) >> SHIFT);

  // NOTE: the bank store has no reset; the full flags alone say what is valid.
  logic [OW-1:0] mem [2][NB];

  always_ff @(posedge i_clk) begin
    if (s1_wr) mem[s1_bank][s1_addr] <= wr_data;
  end

  // ---------------- bank occupancy, drop reporting ----------------
  logic          valid_q, last_q, overrun_q;
  logic [OW-1:0] power_q;
  logic [BW-1:0] bin_q, rd_addr;
  logic          rd_bank, out_bank, release_bank, load;

  assign release_bank = valid_q & bus.i_ready & last_q;
  assign load         = ~valid_q | bus.i_ready;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      full      <= '0;
      overrun_q <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (s1_full && s1_bank == 1'(b))           full[b] <= 1'b1;
        else if (release_bank && out_bank == 1'(b)) full[b] <= 1'b0;
      end
      if (s1_drop) overrun_q <= 1'b1;
    end
  end

`ifdef FFT_POWER_DROPCNT_EN
  logic [15:0] drop_count_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                                drop_count_q <= '0;
    else if (s1_drop && drop_count_q != 16'hFFFF)  drop_count_q <= drop_count_q + 16'd1;
  end

  assign bus.o_drop_count = drop_count_q;
`endif

  // ---------------- readout ----------------
  // rd_bank/rd_addr point at the next bin to load; out_bank owns the bin on the outputs,
  // so a bank is released only when its last bin is actually taken.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid_q  <= 1'b0;
      power_q  <= '0;
      bin_q    <= '0;
      last_q   <= 1'b0;
      rd_addr  <= '0;
      rd_bank  <= 1'b0;
      out_bank <= 1'b0;
    end else if (load) begin
      if (full[rd_bank]) begin
        valid_q  <= 1'b1;
        power_q  <= mem[rd_bank][rd_addr];
        bin_q    <= rd_addr;
        last_q   <= (rd_addr == LAST_BIN);
        out_bank <= rd_bank;
        if (rd_addr == LAST_BIN) begin
          rd_addr <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_addr <= rd_addr + 1'b1;
        end
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_valid   = valid_q;
  assign bus.o_power   = power_q;
  assign bus.o_bin     = bin_q;
  assign bus.o_last    = last_q;
  assign bus.o_overrun = overrun_q;
endmodule
